vga_glyph_overlay: RTL and testbench
====================================

# vga_glyph_overlay

Parametrised on-screen glyph overlay for the VGA controller. Once per frame it fetches field values from the clock/chronometer register memory over a req/ack handshake, converts them to BCD glyph offsets in a shadow bank, and commits the bank atomically. For every pixel it drives the digit or indicator ROM address and chip select through a 2-stage pipeline. It replaces fixed-layout, one-register-per-frame pointer logic with configurable field count and geometry, full-frame fetch, double buffering and a cursor underline.

## Interface
- NUM_FIELDS, 12: displayed fields; memory words 0..NUM_FIELDS-1, cursor word at NUM_FIELDS.
- ADDR_W, 4: memory address width; must satisfy 2^ADDR_W > NUM_FIELDS.
- GLYPH_W, 40 / GLYPH_H, 60: digit glyph size in pixels.
- IND_W, 100 / IND_H, 20: indicator glyph size in pixels.
- CURSOR_H, 5: underline height in rows.
- H_ACTIVE, 640: line stride for background addressing.
- ROM_ADDR_W, 19: ROM address width.
- CLK  in  1  pixel-domain clock.
- RESET  in  1  Asynchronous, active-high reset.
- PosX, PosY  in  10 each  current pixel coordinates.
- MemAddrOut  out  ADDR_W  fetch address.
- MemReq  out  1  fetch request.
- MemAck  in  1  data valid; MemDataIN sampled in the same cycle.
- MemDataIN  in  8  field value.
- ROMAddrOut  out  ROM_ADDR_W  pixel address.
- ROMCS  out  2  00 background, 01 digit ROM, 11 indicator ROM.
- FetchBusy  out  1  fetch in progress.
- Overrun  out  1  sticky; a frame start arrived while busy.

## Operation
- Frame start is the cycle PosX/PosY enters (0,0) from any other value. A held (0,0) does not retrigger.
- Fetch FSM states:
  - IDLE -> FETCH on frame start. FetchBusy=1; MemAddrOut=0.
  - FETCH: MemReq=1, held until MemAck. On ack, store the data in the shadow entry, increment the address and deassert MemReq for one cycle.
  - After the ack for address NUM_FIELDS -> COMMIT.
  - COMMIT: one cycle; copy shadow to display bank and cursor; -> IDLE.
- Frame start while not IDLE: ignored, and Overrun is set. Overrun clears only on RESET.
- Field kind comes from the package table. A digit-pair field stores tens/ones row offsets (digit*GLYPH_H). A flag field stores MemDataIN[0]*IND_H.
- Values 0..99 are converted to BCD by the sub-module. Values >99 use glyph 10 (dash) for both digits. MemDataIN[7] is ignored.
- Pixel hit test: each field has tens and ones boxes (digit fields) or one box (flag fields), inclusive bounds [X, X+W-1], [Y, Y+H-1]. The lowest field index wins on overlap.
- Digit hit: ROMCS=01, ROMAddrOut = (PosX-bx) + GLYPH_W*(PosY-by+offset).
- Flag hit: ROMCS=11, same formula with IND_W.
- Miss: ROMCS=00, ROMAddrOut = PosX + H_ACTIVE*PosY.
- Cursor value c in 1..NUM_FIELDS underlines field c-1: its bottom CURSOR_H rows output the miss result. A value of 0 or >NUM_FIELDS means no cursor.
- All arithmetic is done at ROM_ADDR_W bits, unsigned, with zero-extension.

## Timing
- Reset values: ROMCS=00, ROMAddrOut=0, MemReq=0, MemAddrOut=0, FetchBusy=0, Overrun=0. Display/shadow offsets=0 (shows "00", flags off); cursor=0; FSM IDLE.
- Pixel latency is exactly 2 cycles. Stage 1 registers the hit index and relative coordinates; stage 2 registers the address and CS.
- Fetch starts the cycle after frame start. Minimum fetch length is 2*(NUM_FIELDS+1) cycles, with zero-wait ack.
- The display bank changes only in COMMIT, so the pixel pipeline never sees a partial bank.
- RESET mid-fetch: abort immediately; the display bank returns to reset values.

## Configuration
- VGA_CURSOR_BLINK_EN defined: a 6-bit frame counter increments on each frame start. The underline is blanked only while counter[5]=1, a 64-frame period.
- Without the macro: the underline is permanently blanked whenever the cursor is valid, and no frame counter exists.

## Structure
- Package vga_overlay_pkg holds:
  - field_kind_t enum (DIGIT_PAIR, FLAG);
  - per-field FIELD_KIND, FIELD_X, FIELD_Y, FIELD_XU (ones X) constant arrays;
  - ROMCS encodings;
  - DASH_GLYPH=10.
- Sub-module bin2bcd_clamp: combinational, 7-bit in -> tens/ones nibbles, dash on >99.

## Test plan
- Reset: assert RESET mid-line -> all outputs at reset values immediately. After release, a digit box shows offset 0.
- Fetch handshake: ack with 3-cycle delay, field0=37 -> tens offset 180, ones offset 420. Commit exactly once after address NUM_FIELDS; FetchBusy falls the next cycle.
- Pixel address: field0 tens box at (132,130), value 37, pixel (140,135) -> ROMCS=01, ROMAddrOut=8+40*(5+180)=7408, two cycles later.
- Miss and clamp: pixel (0,1) -> ROMCS=00, address 640. Field value 120 -> both digits use offset 600.
- Cursor: cursor=1 -> rows 185..189 of field0 boxes give ROMCS=00. With VGA_CURSOR_BLINK_EN, rows 185..189 return to 01 during frames 0..31.
- Overrun: generate frame start during FETCH -> Overrun=1; the fetch completes normally with no restart.

Source files
------------

// File: rtl/vga_overlay_pkg.sv
// Shared types, ROM chip-select encodings and the on-screen field layout for vga_glyph_overlay.
package vga_overlay_pkg;

  typedef enum logic {
    DIGIT_PAIR = 1'b0,
    FLAG       = 1'b1
  } field_kind_t;

  localparam int unsigned MAX_FIELDS = 16;
  localparam int unsigned DASH_GLYPH = 10;

  localparam logic [1:0] CS_BG    = 2'b00;
  localparam logic [1:0] CS_DIGIT = 2'b01;
  localparam logic [1:0] CS_IND   = 2'b11;

  // Two rows of four digit pairs, then a row of four indicators; spare entries sit off-screen.
  localparam field_kind_t FIELD_KIND [MAX_FIELDS] = '{
    DIGIT_PAIR, DIGIT_PAIR, DIGIT_PAIR, DIGIT_PAIR,
    DIGIT_PAIR, DIGIT_PAIR, DIGIT_PAIR, DIGIT_PAIR,
    FLAG, FLAG, FLAG, FLAG,
    DIGIT_PAIR, DIGIT_PAIR, DIGIT_PAIR, DIGIT_PAIR
  };
  localparam logic [9:0] FIELD_X [MAX_FIELDS] = '{
    10'd132, 10'd232, 10'd332, 10'd432,
    10'd132, 10'd232, 10'd332, 10'd432,
    10'd100, 10'd220, 10'd340, 10'd460,
    10'd1000, 10'd1000, 10'd1000, 10'd1000
  };
  localparam logic [9:0] FIELD_XU [MAX_FIELDS] = '{
    10'd172, 10'd272, 10'd372, 10'd472,
    10'd172, 10'd272, 10'd372, 10'd472,
    10'd0, 10'd0, 10'd0, 10'd0,
    10'd1000, 10'd1000, 10'd1000, 10'd1000
  };
  localparam logic [9:0] FIELD_Y [MAX_FIELDS] = '{
    10'd130, 10'd130, 10'd130, 10'd130,
    10'd230, 10'd230, 10'd230, 10'd230,
    10'd330, 10'd330, 10'd330, 10'd330,
    10'd1000, 10'd1000, 10'd1000, 10'd1000
  };

endpackage

// File: rtl/vga_glyph_overlay_bin2bcd.sv
// Binary to BCD digit pair; values above 99 render as a pair of dashes.
module bin2bcd_clamp
  import vga_overlay_pkg::*;
(
  input  logic [6:0] binIn,
  output logic [3:0] tens_c,
  output logic [3:0] ones_c
);

  always_comb begin
    tens_c = 4'(DASH_GLYPH);
    ones_c = 4'(DASH_GLYPH);
    if (binIn <= 7'd99) begin
      tens_c = 4'(binIn / 7'd10);
      ones_c = 4'(binIn % 7'd10);
    end
  end

endmodule

// File: rtl/vga_glyph_overlay.sv
// Per-frame field fetch into a shadow bank with atomic commit, plus a 2-stage pixel ROM addresser.
// Optional VGA_CURSOR_BLINK_EN: cursor underline blinks with a 64-frame period.
module vga_glyph_overlay
  import vga_overlay_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 12,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned GLYPH_W    = 40,
  parameter int unsigned GLYPH_H    = 60,
  parameter int unsigned IND_W      = 100,
  parameter int unsigned IND_H      = 20,
  parameter int unsigned CURSOR_H   = 5,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned ROM_ADDR_W = 19
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [9:0]            PosX,
  input  logic [9:0]            PosY,
  output logic [ADDR_W-1:0]     MemAddrOut,
  output logic                  MemReq,
  input  logic                  MemAck,
  input  logic [7:0]            MemDataIN,
  output logic [ROM_ADDR_W-1:0] ROMAddrOut,
  output logic [1:0]            ROMCS,
  output logic                  FetchBusy,
  output logic                  Overrun
);

  typedef logic [ROM_ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, FETCH, GAP, COMMIT} fetch_state_t;

  fetch_state_t state, stateNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic shadowWe, commit;
  logic prevZero, atOrigin, frameStart, underBlank;

  addr_t shTens [NUM_FIELDS];
  addr_t shOnes [NUM_FIELDS];
  addr_t dispTens [NUM_FIELDS];
  addr_t dispOnes [NUM_FIELDS];
  logic [7:0] shCursor, cursorReg;

  logic [3:0] bcdTens, bcdOnes;
  addr_t digTensOff, digOnesOff, flagOff;

  assign atOrigin   = (PosX == 10'd0) && (PosY == 10'd0);
  assign frameStart = atOrigin && !prevZero;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prevZero <= 1'b1;
      Overrun  <= 1'b0;
    end else begin
      prevZero <= atOrigin;
      if (frameStart && state != IDLE) Overrun <= 1'b1;
    end
  end

`ifdef VGA_CURSOR_BLINK_EN
  logic [5:0] frameCnt;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) frameCnt <= 6'd0;
    else if (frameStart) frameCnt <= frameCnt + 6'd1;
  end
  assign underBlank = frameCnt[5];
`else
  assign underBlank = 1'b1;
`endif

  // Fetch FSM: state register and registered handshake outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      MemAddrOut <= '0;
      MemReq     <= 1'b0;
      FetchBusy  <= 1'b0;
    end else begin
      state      <= stateNext;
      MemAddrOut <= memAddrNext;
      MemReq     <= (stateNext == FETCH);
      FetchBusy  <= (stateNext != IDLE);
    end
  end

  always_comb begin
    stateNext   = state;
    memAddrNext = MemAddrOut;
    shadowWe    = 1'b0;
    commit      = 1'b0;
    unique case (state)
      IDLE: begin
        if (frameStart) begin
          stateNext   = FETCH;
          memAddrNext = '0;
        end
      end
      FETCH: begin
        if (MemAck) begin
          shadowWe    = 1'b1;
          memAddrNext = MemAddrOut + ADDR_W'(1);
          stateNext   = (MemAddrOut == ADDR_W'(NUM_FIELDS)) ? COMMIT : GAP;
        end
      end
      GAP:    stateNext = FETCH;
      COMMIT: begin
        commit    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  bin2bcd_clamp uBcd (
    .binIn  (MemDataIN[6:0]),
    .tens_c (bcdTens),
    .ones_c (bcdOnes)
  );

  assign digTensOff = addr_t'(bcdTens) * addr_t'(GLYPH_H);
  assign digOnesOff = addr_t'(bcdOnes) * addr_t'(GLYPH_H);
  assign flagOff    = MemDataIN[0] ? addr_t'(IND_H) : '0;

  // Shadow bank fills during fetch; display bank only moves on COMMIT
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(NUM_FIELDS); i++) begin
        shTens[i]   <= '0;
        shOnes[i]   <= '0;
        dispTens[i] <= '0;
        dispOnes[i] <= '0;
      end
      shCursor  <= 8'd0;
      cursorReg <= 8'd0;
    end else begin
      if (shadowWe) begin
        for (int i = 0; i < int'(NUM_FIELDS); i++) begin
          if (MemAddrOut == ADDR_W'(i)) begin
            shTens[i] <= (FIELD_KIND[i] == FLAG) ? flagOff : digTensOff;
            shOnes[i] <= (FIELD_KIND[i] == FLAG) ? '0 : digOnesOff;
          end
        end
        if (MemAddrOut == ADDR_W'(NUM_FIELDS)) shCursor <= MemDataIN;
      end
      if (commit) begin
        for (int i = 0; i < int'(NUM_FIELDS); i++) begin
          dispTens[i] <= shTens[i];
          dispOnes[i] <= shOnes[i];
        end
        cursorReg <= shCursor;
      end
    end
  end

  function automatic logic inBox(input addr_t px, input addr_t py, input addr_t bx,
                                 input addr_t by, input addr_t w, input addr_t h);
    return (px >= bx) && (px < bx + w) && (py >= by) && (py < by + h);
  endfunction

  // Stage 1: hit test, highest index first so the lowest overlapping field wins
  addr_t px, py, relXC, relYC;
  logic hitC, flagC, onesC, underC;
  logic [ADDR_W-1:0] idxC;

  assign px = addr_t'(PosX);
  assign py = addr_t'(PosY);

  always_comb begin
    hitC   = 1'b0;
    flagC  = 1'b0;
    onesC  = 1'b0;
    underC = 1'b0;
    idxC   = '0;
    relXC  = '0;
    relYC  = '0;
    for (int i = int'(NUM_FIELDS) - 1; i >= 0; i--) begin
      if (FIELD_KIND[i] == FLAG) begin
        if (inBox(px, py, addr_t'(FIELD_X[i]), addr_t'(FIELD_Y[i]), addr_t'(IND_W), addr_t'(IND_H))) begin
          hitC   = 1'b1;
          flagC  = 1'b1;
          onesC  = 1'b0;
          idxC   = ADDR_W'(i);
          relXC  = px - addr_t'(FIELD_X[i]);
          relYC  = py - addr_t'(FIELD_Y[i]);
          underC = (cursorReg == 8'(i + 1)) && (relYC >= addr_t'(IND_H - CURSOR_H));
        end
      end else begin
        if (inBox(px, py, addr_t'(FIELD_XU[i]), addr_t'(FIELD_Y[i]), addr_t'(GLYPH_W), addr_t'(GLYPH_H))) begin
          hitC   = 1'b1;
          flagC  = 1'b0;
          onesC  = 1'b1;
          idxC   = ADDR_W'(i);
          relXC  = px - addr_t'(FIELD_XU[i]);
          relYC  = py - addr_t'(FIELD_Y[i]);
          underC = (cursorReg == 8'(i + 1)) && (relYC >= addr_t'(GLYPH_H - CURSOR_H));
        end
        if (inBox(px, py, addr_t'(FIELD_X[i]), addr_t'(FIELD_Y[i]), addr_t'(GLYPH_W), addr_t'(GLYPH_H))) begin
          hitC   = 1'b1;
          flagC  = 1'b0;
          onesC  = 1'b0;
          idxC   = ADDR_W'(i);
          relXC  = px - addr_t'(FIELD_X[i]);
          relYC  = py - addr_t'(FIELD_Y[i]);
          underC = (cursorReg == 8'(i + 1)) && (relYC >= addr_t'(GLYPH_H - CURSOR_H));
        end
      end
    end
  end

  logic s1Hit, s1Flag, s1Ones;
  logic [ADDR_W-1:0] s1Idx;
  addr_t s1RelX, s1RelY;
  logic [9:0] s1PosX, s1PosY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1Hit  <= 1'b0;
      s1Flag <= 1'b0;
      s1Ones <= 1'b0;
      s1Idx  <= '0;
      s1RelX <= '0;
      s1RelY <= '0;
      s1PosX <= 10'd0;
      s1PosY <= 10'd0;
    end else begin
      s1Hit  <= hitC && !(underC && underBlank);
      s1Flag <= flagC;
      s1Ones <= onesC;
      s1Idx  <= idxC;
      s1RelX <= relXC;
      s1RelY <= relYC;
      s1PosX <= PosX;
      s1PosY <= PosY;
    end
  end

  // Stage 2: glyph or background address
  addr_t offC, widthC, hitAddrC, missAddrC;

  always_comb begin
    offC = '0;
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      if (s1Idx == ADDR_W'(i)) offC = s1Ones ? dispOnes[i] : dispTens[i];
    end
    widthC    = s1Flag ? addr_t'(IND_W) : addr_t'(GLYPH_W);
    hitAddrC  = s1RelX + widthC * (s1RelY + offC);
    missAddrC = addr_t'(s1PosX) + addr_t'(H_ACTIVE) * addr_t'(s1PosY);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ROMCS      <= CS_BG;
      ROMAddrOut <= '0;
    end else begin
      ROMCS      <= s1Hit ? (s1Flag ? CS_IND : CS_DIGIT) : CS_BG;
      ROMAddrOut <= s1Hit ? hitAddrC : missAddrC;
    end
  end

endmodule

// File: tb/tb_vga_glyph_overlay.sv
// Self-checking bench for vga_glyph_overlay: handshake responder, fixed vectors, and a screen-level reference model.
module tb_vga_glyph_overlay;
  import vga_overlay_pkg::*;

  localparam int NF = 12;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  PosX, PosY;
  logic [3:0]  MemAddrOut;
  logic        MemReq, MemAck;
  logic [7:0]  MemDataIN;
  logic [18:0] ROMAddrOut;
  logic [1:0]  ROMCS;
  logic        FetchBusy, Overrun;

  vga_glyph_overlay dut (
    .CLK(CLK), .RESET(RESET), .PosX(PosX), .PosY(PosY),
    .MemAddrOut(MemAddrOut), .MemReq(MemReq), .MemAck(MemAck), .MemDataIN(MemDataIN),
    .ROMAddrOut(ROMAddrOut), .ROMCS(ROMCS), .FetchBusy(FetchBusy), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int mem [16];
  int vals [NF+1];
  int ackDelay = 0;
  int ackLog [$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory side: acknowledges after ackDelay cycles of request and logs each acked address
  initial begin
    int waitCnt;
    waitCnt = 0;
    MemAck = 1'b0;
    MemDataIN = 8'd0;
    forever begin
      @(negedge CLK);
      if (MemAck) MemAck = 1'b0;
      else if (MemReq && !RESET) begin
        if (waitCnt >= ackDelay) begin
          MemAck = 1'b1;
          MemDataIN = 8'(mem[MemAddrOut]);
          ackLog.push_back(int'(MemAddrOut));
          waitCnt = 0;
        end else waitCnt++;
      end
    end
  end

  // What the screen should show at (x,y) given the committed field values
  function automatic void refPixel(input int x, input int y, output int cs, output int addr);
    int v, c, w, h, bx, by, off, g;
    bit isFlag;
    cs = 0;
    addr = x + 640 * y;
    c = vals[NF];
    for (int i = 0; i < NF; i++) begin
      isFlag = (FIELD_KIND[i] == FLAG);
      v = vals[i] % 128;
      for (int b = 0; b < 2; b++) begin
        if (isFlag && b == 1) continue;
        w = isFlag ? 100 : 40;
        h = isFlag ? 20 : 60;
        bx = (b == 0) ? int'(FIELD_X[i]) : int'(FIELD_XU[i]);
        by = int'(FIELD_Y[i]);
        if (x >= bx && x < bx + w && y >= by && y < by + h) begin
          if (c >= 1 && c <= NF && c - 1 == i && y >= by + h - 5) return;
          if (isFlag) off = (vals[i] % 2) * 20;
          else begin
            g = (v > 99) ? 10 : ((b == 0) ? v / 10 : v % 10);
            off = g * 60;
          end
          cs = isFlag ? 3 : 1;
          addr = (x - bx) + w * ((y - by) + off);
          return;
        end
      end
    end
  endfunction

  task automatic pixel(input int x, input int y, output int cs, output int addr);
    PosX = 10'(x);
    PosY = 10'(y);
    @(negedge CLK);
    @(negedge CLK);
    cs = int'(ROMCS);
    addr = int'(ROMAddrOut);
  endtask

  task automatic pixelCheck(input string name, input int x, input int y, input int ecs, input int eaddr);
    int cs, addr;
    pixel(x, y, cs, addr);
    check({name, "_cs"}, cs, ecs);
    check({name, "_addr"}, addr, eaddr);
  endtask

  // Runs one frame-start-triggered fetch; optionally fires a second frame start mid-fetch
  task automatic doFetch(input int delay, input int glitchAt, input int expBusy);
    int busy, late;
    bit seqOk;
    ackDelay = delay;
    ackLog.delete();
    PosX = 10'd1; PosY = 10'd1;
    @(negedge CLK);
    PosX = 10'd0; PosY = 10'd0;
    busy = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (FetchBusy) begin
        busy++;
        if (busy == glitchAt) PosX = 10'd3;
        if (busy == glitchAt + 1) PosX = 10'd0;
      end else if (busy > 0) break;
    end
    check("fetch_len", busy, expBusy);
    seqOk = (ackLog.size() == NF + 1);
    if (seqOk) for (int k = 0; k <= NF; k++) if (ackLog[k] != k) seqOk = 1'b0;
    check("fetch_addr_seq", seqOk, 1);
    late = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (FetchBusy) late++;
    end
    check("fetch_no_restart", late, 0);
    for (int k = 0; k <= NF; k++) vals[k] = mem[k];
  endtask

  typedef struct {
    int x;
    int y;
    int cs;
    int addr;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int cs, addr, ecs, eaddr, x, y, f, d;

    vecs[0] = '{0, 1, 0, 640};
    vecs[1] = '{140, 135, 1, 7408};
    vecs[2] = '{131, 135, 0, 86531};
    vecs[3] = '{171, 189, 1, 9599};
    vecs[4] = '{172, 130, 1, 16800};
    vecs[5] = '{100, 330, 3, 2000};
    vecs[6] = '{199, 349, 3, 3999};
    vecs[7] = '{200, 349, 0, 223560};

    RESET = 1'b1;
    PosX = 10'd5; PosY = 10'd3;
    for (int k = 0; k < 16; k++) mem[k] = 0;
    for (int k = 0; k <= NF; k++) vals[k] = 0;
    repeat (3) @(negedge CLK);
    check("rst_romcs", ROMCS, 0);
    check("rst_romaddr", ROMAddrOut, 0);
    check("rst_memreq", MemReq, 0);
    check("rst_memaddr", MemAddrOut, 0);
    check("rst_busy", FetchBusy, 0);
    check("rst_overrun", Overrun, 0);
    RESET = 1'b0;
    @(negedge CLK);

    pixelCheck("reset_bank", 140, 135, 1, 208);

    for (int k = 0; k < NF; k++) mem[k] = int'($urandom_range(0, 255));
    mem[0] = 37;
    mem[8] = 1;
    mem[NF] = 0;
    doFetch(3, -1, 13 * 5);

    for (int i = 0; i < 8; i++) begin
      pixel(vecs[i].x, vecs[i].y, cs, addr);
      check($sformatf("vec%0d_cs", i), cs, vecs[i].cs);
      check($sformatf("vec%0d_addr", i), addr, vecs[i].addr);
    end

    mem[0] = 120;
    doFetch(0, -1, 26);
    pixelCheck("clamp_tens", 140, 135, 1, 24208);
    pixelCheck("clamp_ones", 172, 130, 1, 24000);

    mem[NF] = 1;
    doFetch(0, -1, 26);
    pixelCheck("cursor_tens", 140, 185, 0, 118540);
    pixelCheck("cursor_above", 140, 184, 1, 26168);
    pixelCheck("cursor_ones", 175, 187, 0, 119855);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NF; k++) mem[k] = int'($urandom_range(0, 255));
      mem[NF] = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 2));
      doFetch(d, -1, 13 * (d + 2));
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 3) != 0) begin
          f = int'($urandom_range(0, NF - 1));
          x = int'(FIELD_X[f]) - 2 + int'($urandom_range(0, 86));
          y = int'(FIELD_Y[f]) - 2 + int'($urandom_range(0, 64));
        end else begin
          x = int'($urandom_range(1, 639));
          y = int'($urandom_range(0, 479));
        end
        pixel(x, y, cs, addr);
        refPixel(x, y, ecs, eaddr);
        check($sformatf("rand_px_%0d_%0d", x, y), longint'(cs) * 1048576 + addr,
              longint'(ecs) * 1048576 + eaddr);
      end
    end

    check("overrun_before", Overrun, 0);
    doFetch(0, 10, 26);
    check("overrun_set", Overrun, 1);
    repeat (3) @(negedge CLK);
    check("overrun_sticky", Overrun, 1);

    PosX = 10'd140; PosY = 10'd135;
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("midrst_romcs", ROMCS, 0);
    check("midrst_romaddr", ROMAddrOut, 0);
    check("midrst_memreq", MemReq, 0);
    check("midrst_memaddr", MemAddrOut, 0);
    check("midrst_busy", FetchBusy, 0);
    check("midrst_overrun", Overrun, 0);
    @(negedge CLK);
    RESET = 1'b0;
    pixelCheck("midrst_bank", 140, 135, 1, 208);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
